bk_adder_pipe: RTL and testbench

- Parametrised, pipelined Brent-Kung prefix adder/subtractor; successor to the fixed 12-bit combinational Brent-Kung netlist.
- Generalised in width, pipeline depth and mode (add/sub, carry-in, signed overflow).
- Valid/ready handshake on both sides with full-throughput backpressure.
- Sits between operand-issue logic and the result writeback path of the datapath playground.

---
 rtl/bk_pkg.sv | 39 +++
 rtl/bk_pipe_stage.sv | 43 ++++
 rtl/bk_adder_pipe.sv | 119 +++++++++++
 tb/tb_bk_adder_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared helpers for the pipelined Brent-Kung adder: level count, level-to-stage
// mapping and the generate/propagate pair with its prefix combine operator.
package bk_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic int bk_levels(input int width);
      return 2 * $clog2(width) - 1;
   endfunction

   // Levels are dealt out as evenly as possible; earlier stages absorb the remainder.
   function automatic int bk_stage_of_level(input int level, input int nlevels, input int stages);
      int acc;
      int stage;
      logic found;
      acc   = 0;
      stage = stages - 1;
      found = 1'b0;
      for (int s = 0; s < stages; s++) begin
         acc = acc + nlevels / stages + ((s < nlevels % stages) ? 1 : 0);
         if (!found && level < acc) begin
            stage = s;
            found = 1'b1;
         end
      end
      return stage;
   endfunction

   function automatic gp_t gp_comb(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/bk_pipe_stage.sv
// One pipeline register slice: a valid bit plus an opaque payload, with the
// bubble-collapsing advance rule (an empty slice always accepts).
module bk_pipe_stage #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   input  logic          adv_next_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   output logic          adv_o
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   assign adv_o = !valid_q || adv_next_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (adv_o) begin
         valid_d = valid_i;
         if (valid_i) data_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready on both sides.
// The carry-in is combined with the group (G,P) after the last stage, acting as bit -1.
module bk_adder_pipe
   import bk_pkg::*;
#(
   parameter int WIDTH  = 12,
   parameter int STAGES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int LOG     = $clog2(WIDTH);
   localparam int NLEVELS = bk_levels(WIDTH);

   typedef gp_t [WIDTH-1:0] gpv_t;

   typedef struct packed {
      logic             c0;
      logic [WIDTH-1:0] p0;
      gpv_t             gp;
   } pay_t;

   localparam int DW = $bits(pay_t);

   // Up-sweep for lvl < LOG, then the down-sweep fills in the remaining prefixes.
   function automatic gpv_t bk_level(input gpv_t v, input int lvl);
      gpv_t r;
      int   span;
      r = v;
      if (lvl < LOG) begin
         span = 1 << lvl;
         for (int i = 0; i < WIDTH; i++)
            if ((i + 1) % (2 * span) == 0) r[i] = gp_comb(v[i], v[i-span]);
      end else begin
         span = 1 << (2 * LOG - 2 - lvl);
         for (int i = 0; i < WIDTH; i++)
            if (((i + 1) % (2 * span) == span) && (i > span)) r[i] = gp_comb(v[i], v[i-span]);
      end
      return r;
   endfunction

   pay_t             pre;
   logic [WIDTH-1:0] b_eff;
   pay_t             st_q [STAGES];
   logic [STAGES-1:0] vld_in, vld_q;
   logic [STAGES:0]   adv;

   always_comb begin
      b_eff  = in_sub ? ~in_b : in_b;
      pre.c0 = in_sub | in_cin;
      pre.p0 = in_a ^ b_eff;
      for (int i = 0; i < WIDTH; i++) begin
         pre.gp[i].g = in_a[i] & b_eff[i];
         pre.gp[i].p = in_a[i] ^ b_eff[i];
      end
   end

   assign adv[STAGES] = out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pay_t src, nxt;

      if (k == 0) begin : g_head
         assign src       = pre;
         assign vld_in[k] = in_valid;
      end else begin : g_body
         assign src       = st_q[k-1];
         assign vld_in[k] = vld_q[k-1];
      end

      always_comb begin
         nxt = src;
         for (int l = 0; l < NLEVELS; l++)
            if (bk_stage_of_level(l, NLEVELS, STAGES) == k) nxt.gp = bk_level(nxt.gp, l);
      end

      bk_pipe_stage #(.DW(DW)) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .valid_i   (vld_in[k]),
         .data_i    (nxt),
         .adv_next_i(adv[k+1]),
         .valid_o   (vld_q[k]),
         .data_o    (st_q[k]),
         .adv_o     (adv[k])
      );
   end

   assign in_ready = adv[0] & rst_n;

   pay_t           last;
   logic [WIDTH:0] carry;

   assign last = st_q[STAGES-1];

   always_comb begin
      carry[0] = last.c0;
      for (int i = 0; i < WIDTH; i++)
         carry[i+1] = last.gp[i].g | (last.gp[i].p & last.c0);
   end

   assign out_valid = vld_q[STAGES-1];
   assign out_sum   = last.p0 ^ carry[WIDTH-1:0];
   assign out_cout  = carry[WIDTH];
   assign out_ovf   = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Directed and random bench for bk_adder_pipe: expected {ovf,cout,sum} queued at
// input transfer, compared in order at output transfer.
module tb_bk_adder_pipe;

   localparam int W = 12;
   localparam int S = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, in_cin, in_sub;
   logic [W-1:0] in_a, in_b, out_sum;
   logic         out_valid, out_ready, out_cout, out_ovf;

   int           check_cnt = 0;
   int           err_cnt = 0;
   logic [W+1:0] exp_q[$];
   logic         rnd_done;
   logic         stall_seen = 1'b0;
   logic [W+1:0] held;

   always #5 clk = ~clk;

   bk_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_cin   (in_cin),
      .in_sub   (in_sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_cout (out_cout),
      .out_ovf  (out_ovf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
      logic [W-1:0] bx;
      logic [W:0]   ext;
      logic         ovf;
      bx  = sub ? ~b : b;
      ext = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sub | cin)};
      ovf = (a[W-1] == bx[W-1]) && (ext[W-1] != a[W-1]);
      return {ovf, ext};
   endfunction

   task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                             input logic sub, input logic [W+1:0] exp, output int waits);
      logic done;
      waits = 0;
      done  = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(exp);
            done = 1'b1;
         end else begin
            waits++;
            if (waits > 200) begin
               chk("accept_timeout", 64'(waits), 64'(0));
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic send_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, input logic [W+1:0] exp);
      int w;
      int lat;
      drive_beat(a, b, cin, sub, exp, w);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(S));
      chk("direct_result", 64'({out_ovf, out_cout, out_sum}), 64'(exp));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'(0));
   endtask

   // Scoreboard: compare at each output transfer and check held outputs while stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         stall_seen = 1'b0;
      end else begin
         if (stall_seen && out_valid)
            chk("hold", 64'({out_ovf, out_cout, out_sum}), 64'(held));
         if (out_valid && out_ready) begin
            check_cnt++;
            assert (exp_q.size() != 0) else begin
               err_cnt++;
               $error("FAIL unexpected_out: observed 0x%0h expected no beat", {out_ovf, out_cout, out_sum});
            end
            if (exp_q.size() != 0)
               chk("result", 64'({out_ovf, out_cout, out_sum}), 64'(exp_q.pop_front()));
         end
         stall_seen = out_valid && !out_ready;
         held       = {out_ovf, out_cout, out_sum};
      end
   end

   initial begin
      int w;
      int total_w;
      logic [W-1:0] ra, rb;
      logic rc, rs;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      out_ready = 1'b1; rnd_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 64'(in_ready), 64'(0));
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_out_all", 64'({out_ovf, out_cout, out_sum}), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 64'(in_ready), 64'(1));
      chk("idle_out_valid", 64'(out_valid), 64'(0));

      // Directed vectors with constant expectations {ovf, cout, sum}
      send_lat(12'hFFF, 12'h001, 1'b0, 1'b0, {1'b0, 1'b1, 12'h000});
      send_lat(12'h7FF, 12'h000, 1'b1, 1'b0, {1'b1, 1'b0, 12'h800});
      send_lat(12'h800, 12'h001, 1'b0, 1'b1, {1'b1, 1'b1, 12'h7FF});
      send_lat(12'h000, 12'h001, 1'b1, 1'b1, {1'b0, 1'b0, 12'hFFF});
      idle(3);

      // Backpressure: three beats fill the pipe, the fourth must wait
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) drive_beat(W'(i), W'(i), 1'b0, 1'b0, {2'b00, W'(2 * i)}, w);
      @(posedge clk); #1;
      in_a = W'(3); in_b = W'(3);
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'(0));
      chk("full_out_valid", 64'(out_valid), 64'(1));
      chk("full_out_sum", 64'(out_sum), 64'(0));
      fork
         begin
            for (int i = 3; i < 8; i++) drive_beat(W'(i), W'(i), 1'b0, 1'b0, {2'b00, W'(2 * i)}, w);
            idle(1);
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();

      // Sustained throughput with a full, draining pipe
      total_w = 0;
      for (int i = 0; i < 16; i++) begin
         ra = W'($urandom()); rb = W'($urandom()); rc = 1'($urandom()); rs = 1'($urandom());
         drive_beat(ra, rb, rc, rs, model(ra, rb, rc, rs), w);
         total_w += w;
      end
      idle(1);
      chk("throughput_waits", 64'(total_w), 64'(0));
      wait_drain();

      // Reset with three beats in flight
      for (int i = 0; i < 3; i++) drive_beat(12'h0AA, W'(i), 1'b0, 1'b0, model(12'h0AA, W'(i), 1'b0, 1'b0), w);
      @(posedge clk); #1;
      rst_n = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_out_all", 64'({out_ovf, out_cout, out_sum}), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_lat(12'h123, 12'h456, 1'b0, 1'b0, {2'b00, 12'h579});
      idle(2);

      // Random sweep with random gaps and random downstream readiness
      fork
         begin
            for (int n = 0; n < 400; n++) begin
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
               ra = W'($urandom()); rb = W'($urandom()); rc = 1'($urandom()); rs = 1'($urandom());
               if ($urandom_range(0, 7) == 0) rb = W'(0);
               drive_beat(ra, rb, rc, rs, model(ra, rb, rc, rs), w);
            end
            idle(1);
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
      $finish;
   end

endmodule
